clk_monitor: RTL and testbench
==============================

CLK_MONITOR -- requirements
Module: clk_monitor

Interface
REQ-001 SHALL have parameter WINDOW, default 27000, meaning gate length in clk cycles (1 ms at 27 MHz).
REQ-002 SHALL have parameter CNT_MIN, default 3800, meaning lowest acceptable edge count per window.
REQ-003 SHALL have parameter CNT_MAX, default 3915, meaning highest acceptable edge count per window.
REQ-004 SHALL have parameter LOCK_WINDOWS, default 4, meaning consecutive good windows required to declare lock.
REQ-005 SHALL have parameter CNT_W, default 16, meaning width of the edge counter and freq_count.
REQ-006 SHALL have port clk, input, 1, 27 MHz reference clock; the only clock.
REQ-007 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-008 SHALL have port enable, input, 1, monitoring enable.
REQ-009 SHALL have port mon_in, input, 1, monitored PLL output, asynchronous to clk.
REQ-010 SHALL have port clear, input, 1, single-cycle clear of sticky fault.
REQ-011 SHALL have port freq_count, output, CNT_W, rising-edge count of the last completed window.
REQ-012 SHALL have port count_valid, output, 1, one-cycle pulse when freq_count updates.
REQ-013 SHALL have port locked, output, 1, monitored clock in range.
REQ-014 SHALL have port fault, output, 1, sticky out-of-range indicator.

Function
REQ-015 SHALL pass mon_in through a 2-flop synchronizer plus one history flop; a rising edge is synchronized=1 and history=0.
REQ-016 SHALL count clk cycles 0..WINDOW-1 in a window counter; window end is the cycle where the window counter equals WINDOW-1.
REQ-017 SHALL count rising edges during the window; the edge counter SHALL saturate at all-ones and never wrap.
REQ-018 At window end SHALL load freq_count with the edge count (including an edge detected in that same cycle), pulse count_valid for one cycle, and restart both counters at 0 on the next cycle.
REQ-019 SHALL classify a window as good when CNT_MIN <= count <= CNT_MAX, bounds inclusive, with unsigned comparison.
REQ-020 SHALL implement the FSM states DISABLED, ACQUIRE, LOCKED, and LOST.
REQ-021 DISABLED: counters held at 0 and locked=0; enable=1 SHALL move to ACQUIRE on the next cycle.
REQ-022 ACQUIRE: each good window SHALL increment a good-run counter and each bad window SHALL zero it; on reaching LOCK_WINDOWS the FSM SHALL move to LOCKED and assert locked in the same cycle as that window's count_valid.
REQ-023 LOCKED: a bad window SHALL deassert locked, set fault, and move to LOST, all in the cycle of count_valid.
REQ-024 LOST: SHALL behave as ACQUIRE (good-run restarts at 0) and SHALL return to LOCKED after LOCK_WINDOWS good windows.
REQ-025 enable=0 in any state SHALL move to DISABLED next cycle, abort the current window without a count_valid pulse, and retain freq_count and fault.
REQ-026 clear SHALL zero fault; if clear coincides with a fault-setting event, fault SHALL end at 1 (set wins).
REQ-027 Window end in ACQUIRE or LOST SHALL never set fault.
REQ-028 mon_in stuck at either level SHALL yield count 0, classified bad.

Reset
REQ-029 rst SHALL asynchronously force: state DISABLED, all counters 0, synchronizer and history flops 0, freq_count=0, count_valid=0, locked=0, fault=0.
REQ-030 Reset asserted mid-window SHALL discard that partial window; after release the first window SHALL start fresh when enable=1.

Structure
REQ-031 SHALL place the FSM state enumeration and default constants (WINDOW, CNT_MIN, CNT_MAX, LOCK_WINDOWS) in the shared package clk_monitor_pkg.
REQ-032 SHALL place the synchronizer and edge detector in a sub-module sync_edge_det; all remaining logic SHALL reside in clk_monitor.

Verification
REQ-033 enable=1; mon_in square wave with period 7 clk → each freq_count = 3857±1; locked=1 at the 4th count_valid; fault=0.
REQ-034 Locked, then mon_in period changed to 6 clk (count 4500) → locked=0 and fault=1 at the next count_valid; state LOST; restoring period 7 → relocks after 4 windows with fault still 1.
REQ-035 mon_in held at 0 → freq_count=0 each window; locked stays 0; fault stays 0.
REQ-036 Boundary: reduced parameters WINDOW=100, CNT_MIN=10, CNT_MAX=20; exactly 10 and exactly 20 edges are good; 9 and 21 edges are bad.
REQ-037 clear asserted in the same cycle as a fault-setting count_valid → fault=1; clear on a later cycle → fault=0.
REQ-038 rst asserted mid-window while LOCKED → all outputs 0 immediately, without waiting for a clk edge; after release the first count_valid comes exactly WINDOW cycles after counting resumes.

Source files
------------

// File: rtl/clk_monitor_pkg.sv
// Shared FSM encoding and default gate/limit constants for the PLL clock monitor.
package clk_monitor_pkg;

  typedef enum logic [1:0] {
    StDisabled,
    StAcquire,
    StLocked,
    StLost
  } state_e;

  // 1 ms gate at 27 MHz; limits bracket the nominal 3857 edges/window.
  localparam int unsigned DefWindow      = 27000;
  localparam int unsigned DefCntMin      = 3800;
  localparam int unsigned DefCntMax      = 3915;
  localparam int unsigned DefLockWindows = 4;
  localparam int unsigned DefCntW        = 16;

endpackage

// File: rtl/sync_edge_det.sv
// Brings the asynchronous monitored clock into the clk domain and flags its rising edges.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      sync1 <= async_in;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign rise = sync2 & ~hist;

endmodule

// File: rtl/clk_monitor.sv
// Gated frequency counter for a PLL output with lock detection and a sticky range fault.
module clk_monitor
  import clk_monitor_pkg::*;
#(
  parameter int unsigned WINDOW       = DefWindow,
  parameter int unsigned CNT_MIN      = DefCntMin,
  parameter int unsigned CNT_MAX      = DefCntMax,
  parameter int unsigned LOCK_WINDOWS = DefLockWindows,
  parameter int unsigned CNT_W        = DefCntW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             mon_in,
  input  logic             clear,
  output logic [CNT_W-1:0] freq_count,
  output logic             count_valid,
  output logic             locked,
  output logic             fault
);

  localparam int unsigned WinW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int unsigned RunW = $clog2(LOCK_WINDOWS + 1);

  localparam logic [WinW-1:0]  WinLast = WinW'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CntMin  = CNT_W'(CNT_MIN);
  localparam logic [CNT_W-1:0] CntMax  = CNT_W'(CNT_MAX);
  localparam logic [RunW-1:0]  RunLast = RunW'(LOCK_WINDOWS - 1);

  state_e           state_q, state_d;
  logic [WinW-1:0]  win_q, win_d;
  logic [CNT_W-1:0] edge_q, edge_d;
  logic [RunW-1:0]  run_q, run_d;
  logic [CNT_W-1:0] freq_q, freq_d;
  logic             cv_q, cv_d;
  logic             fault_q, fault_d;

  logic             rise;
  logic [CNT_W-1:0] cnt_final;
  logic             good;
  logic             fault_set;

  sync_edge_det u_sync_edge_det (
    .clk      (clk),
    .rst      (rst),
    .async_in (mon_in),
    .rise     (rise)
  );

  // Include an edge seen in the current cycle, saturating rather than wrapping.
  assign cnt_final = (rise && (edge_q != '1)) ? edge_q + CNT_W'(1) : edge_q;
  assign good      = (cnt_final >= CntMin) && (cnt_final <= CntMax);

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    edge_d    = edge_q;
    run_d     = run_q;
    freq_d    = freq_q;
    cv_d      = 1'b0;
    fault_d   = fault_q;
    fault_set = 1'b0;

    if (!enable) begin
      state_d = StDisabled;
      win_d   = '0;
      edge_d  = '0;
      run_d   = '0;
    end else begin
      case (state_q)
        StDisabled: state_d = StAcquire;
        default: begin
          if (win_q == WinLast) begin
            win_d  = '0;
            edge_d = '0;
            freq_d = cnt_final;
            cv_d   = 1'b1;
            if (state_q == StLocked) begin
              if (!good) begin
                state_d   = StLost;
                fault_set = 1'b1;
                run_d     = '0;
              end
            end else if (!good) begin
              run_d = '0;
            end else if (run_q == RunLast) begin
              state_d = StLocked;
              run_d   = '0;
            end else begin
              run_d = run_q + RunW'(1);
            end
          end else begin
            win_d  = win_q + WinW'(1);
            edge_d = cnt_final;
          end
        end
      endcase
    end

    // Set dominates a coincident clear.
    if (clear) fault_d = 1'b0;
    if (fault_set) fault_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StDisabled;
      win_q   <= '0;
      edge_q  <= '0;
      run_q   <= '0;
      freq_q  <= '0;
      cv_q    <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      edge_q  <= edge_d;
      run_q   <= run_d;
      freq_q  <= freq_d;
      cv_q    <= cv_d;
      fault_q <= fault_d;
    end
  end

  assign freq_count  = freq_q;
  assign count_valid = cv_q;
  assign locked      = (state_q == StLocked);
  assign fault       = fault_q;

endmodule

// File: tb/tb_clk_monitor.sv
// Randomized scoreboard bench for clk_monitor using a reduced gate of 100 cycles.
module tb_clk_monitor;

  localparam int unsigned W   = 100;
  localparam int unsigned MIN = 10;
  localparam int unsigned MAX = 20;
  localparam int unsigned LW  = 4;
  localparam int unsigned CW  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          mon_in;
  logic          clear;
  logic [CW-1:0] freq_count;
  logic          count_valid;
  logic          locked;
  logic          fault;

  always #5 clk = ~clk;

  clk_monitor #(
    .WINDOW       (W),
    .CNT_MIN      (MIN),
    .CNT_MAX      (MAX),
    .LOCK_WINDOWS (LW),
    .CNT_W        (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .mon_in      (mon_in),
    .clear       (clear),
    .freq_count  (freq_count),
    .count_valid (count_valid),
    .locked      (locked),
    .fault       (fault)
  );

  typedef struct packed {
    logic [CW-1:0] cnt;
    logic          lk;
    logic          ft;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   cv_cyc = 0;
  int   rel    = 0;

  // Reference model state: abstract lock bookkeeping, not the RTL encoding.
  int   m_run    = 0;
  bit   m_locked = 0;
  bit   m_fault  = 0;
  int   m_last   = 0;
  bit   prev_high = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_window(input int cnt, input bit clr);
    bit good;
    exp_t e;
    good = (cnt >= int'(MIN)) && (cnt <= int'(MAX));
    if (clr) m_fault = 0;
    if (m_locked) begin
      if (!good) begin
        m_locked = 0;
        m_fault  = 1;
        m_run    = 0;
      end
    end else begin
      m_run = good ? m_run + 1 : 0;
      if (m_run == int'(LW)) begin
        m_locked = 1;
        m_run    = 0;
      end
    end
    m_last = cnt;
    e.cnt  = CW'(cnt);
    e.lk   = m_locked;
    e.ft   = m_fault;
    sb_q.push_back(e);
  endtask

  // mode 0: n one-cycle pulses away from the window edges; mode 1: mon_in held high.
  task automatic run_window(input int mode, input int n, input bit clr_mid, input bit clr_end);
    int cnt;
    for (int i = 0; i < int'(W); i++) begin
      @(negedge clk);
      if (mode == 1) mon_in = 1'b1;
      else mon_in = (i >= 4) && (i < 4 + 2 * n) && (((i - 4) % 2) == 0);
      clear = (clr_mid && i == int'(W) / 2) || (clr_end && i == int'(W) - 1);
    end
    cnt = (mode == 1) ? (prev_high ? 0 : 1) : n;
    prev_high = (mode == 1);
    model_window(cnt, clr_mid || clr_end);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      clear  = 1'b0;
      mon_in = 1'b0;
    end
    prev_high = 0;
  endtask

  function automatic int pick_n();
    case ($urandom_range(0, 5))
      0:       return 9;
      1:       return 10;
      2:       return 20;
      3:       return 21;
      default: return int'($urandom_range(8, 23));
    endcase
  endfunction

  // Monitor: every count_valid pulse must match the oldest expected window.
  initial begin
    exp_t e;
    int   idx = 0;
    forever begin
      @(negedge clk);
      if (count_valid === 1'b1) begin
        cv_cyc = cyc;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_count_valid: got pulse at cycle %0d expected none", cyc);
        end else begin
          e = sb_q.pop_front();
          check($sformatf("win%0d_freq_count", idx), 32'(freq_count), 32'(e.cnt));
          check($sformatf("win%0d_locked", idx), 32'(locked), 32'(e.lk));
          check($sformatf("win%0d_fault", idx), 32'(fault), 32'(e.ft));
        end
        idx++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b1;
    enable = 1'b0;
    mon_in = 1'b0;
    clear  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_freq_count", 32'(freq_count), 0);
    check("reset_count_valid", 32'(count_valid), 0);
    check("reset_locked", 32'(locked), 0);
    check("reset_fault", 32'(fault), 0);
    rst = 1'b0;
    idle(2);

    @(negedge clk);
    enable = 1'b1;
    for (int k = 0; k < 5; k++) run_window(0, int'($urandom_range(MIN, MAX)), 0, 0);
    // Out-of-range while locked with a coincident clear: fault must still set.
    run_window(0, 21, 0, 1);
    for (int k = 0; k < 4; k++) run_window(0, int'($urandom_range(MIN, MAX)), 0, 0);
    run_window(0, int'($urandom_range(MIN, MAX)), 1, 0);

    run_window(0, 9, 0, 0);
    run_window(0, 10, 0, 0);
    run_window(0, 20, 0, 0);
    run_window(0, 10, 0, 0);
    run_window(0, 20, 0, 0);
    run_window(0, 21, 0, 0);
    run_window(0, 0, 1, 0);
    run_window(0, 0, 0, 0);
    run_window(0, 0, 0, 0);
    run_window(1, 0, 0, 0);
    run_window(1, 0, 0, 0);

    for (int k = 0; k < 24; k++)
      run_window(0, pick_n(), $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);

    // Abort a window with enable low: no pulse, count and fault retained.
    for (int i = 0; i < int'(W) / 2; i++) begin
      @(negedge clk);
      mon_in = (i >= 4) && ((i % 2) == 0);
      clear  = 1'b0;
    end
    @(negedge clk);
    enable = 1'b0;
    mon_in = 1'b0;
    idle(5);
    m_locked = 0;
    m_run    = 0;
    check("abort_locked", 32'(locked), 0);
    check("abort_freq_count", 32'(freq_count), 32'(m_last));
    check("abort_fault", 32'(fault), 32'(m_fault));

    @(negedge clk);
    enable = 1'b1;
    for (int k = 0; k < 4; k++) run_window(0, 15, 0, 0);
    run_window(0, 9, 0, 0);
    for (int k = 0; k < 4; k++) run_window(0, 12, 0, 0);

    // Async reset mid-window while locked with fault set.
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      mon_in = (i >= 4) && ((i % 2) == 0);
      clear  = 1'b0;
    end
    #2;
    rst = 1'b1;
    #1;
    check("midreset_freq_count", 32'(freq_count), 0);
    check("midreset_count_valid", 32'(count_valid), 0);
    check("midreset_locked", 32'(locked), 0);
    check("midreset_fault", 32'(fault), 0);
    m_locked  = 0;
    m_run     = 0;
    m_fault   = 0;
    m_last    = 0;
    mon_in    = 1'b0;
    prev_high = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    rel = cyc;
    run_window(0, 15, 0, 0);
    @(negedge clk);
    #1;
    check("resume_latency", 32'(cv_cyc - (rel + 1)), 32'(W));

    idle(3);
    check("scoreboard_drained", 32'(sb_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
